bank_scheduler: RTL and testbench

Per-bank request scheduler between the front end's bank queues and the back end's command path. Each cycle it picks one bank request using round-robin order, read/write mode batching and per-bank busy timers. It pops the chosen request from its bank queue with a one-hot grant and holds it in an output register until the back end accepts it. It replaces the flat `out`/`grant_i` wiring between front end and back end.

---
 rtl/bank_scheduler.sv | 135 +++++++++++++
 tb/tb_bank_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_scheduler.sv
// Round-robin bank request scheduler with read/write batching and per-bank busy timers.
// Holds the granted request in an output register until the back end accepts it.
module bank_scheduler #(
  parameter int BANKS        = 16,
  parameter int REQ_SIZE     = 50,
  parameter int T_BANK_BUSY  = 8,
  parameter int T_TURNAROUND = 4,
  parameter int WR_BATCH     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BANKS-1:0]               req_valid,
  input  logic [BANKS-1:0]               req_type,
  input  logic [BANKS-1:0][REQ_SIZE-1:0] req_data,
  output logic [BANKS-1:0]               grant_o,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [REQ_SIZE-1:0]            out_req,
  output logic                           out_type,
  output logic [$clog2(BANKS)-1:0]       out_bank
);
  localparam int IW = $clog2(BANKS);
  localparam int BW = $clog2(T_BANK_BUSY + 1);
  localparam int TW = $clog2(T_TURNAROUND + 1);
  localparam int CW = $clog2(WR_BATCH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, TURN} state_t;

  state_t         state_reg;
  logic           mode_reg;
  logic [IW-1:0]  ptr_reg;
  logic [CW-1:0]  batch_reg;
  logic [TW-1:0]  turn_reg;

  logic [BANKS-1:0] elig;
  logic [BANKS-1:0] other;
  logic             any_elig;
  logic             any_other;
  logic [IW-1:0]    sel;
  logic             handshake;
  logic             do_switch;
  logic             do_grant;

  assign handshake = (state_reg == ISSUE) && out_ready;

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic [BW-1:0] busy_reg;

    assign elig[gi]  = req_valid[gi] && (busy_reg == '0) && (req_type[gi] == mode_reg);
    assign other[gi] = req_valid[gi] && (req_type[gi] != mode_reg);

    // A fresh handshake on this bank wins over the running countdown.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy_reg <= '0;
      end else if (handshake && (out_bank == IW'(gi))) begin
        busy_reg <= BW'(T_BANK_BUSY);
      end else if (busy_reg != '0) begin
        busy_reg <= busy_reg - 1'b1;
      end
    end
  end

  assign any_other = |other;

  // Descending scan so the bank closest after ptr_reg is the one left in sel.
  always_comb begin
    logic [IW-1:0] idx;
    idx      = '0;
    sel      = '0;
    any_elig = 1'b0;
    for (int i = BANKS; i >= 1; i--) begin
      idx = IW'((int'(ptr_reg) + i) % BANKS);
      if (elig[idx]) begin
        sel      = idx;
        any_elig = 1'b1;
      end
    end
  end

  assign do_switch = (state_reg == IDLE) && any_other &&
                     (!any_elig || (batch_reg == CW'(WR_BATCH)));
  assign do_grant  = (state_reg == IDLE) && !do_switch && any_elig;

  // Gated by rst_n so the front end never pops while the scheduler is held in reset.
  assign grant_o = (do_grant && rst_n) ? (BANKS'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      ptr_reg   <= IW'(BANKS - 1);
      batch_reg <= '0;
      turn_reg  <= '0;
      out_valid <= 1'b0;
      out_req   <= '0;
      out_type  <= 1'b0;
      out_bank  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_switch) begin
            mode_reg  <= ~mode_reg;
            batch_reg <= '0;
            turn_reg  <= TW'(T_TURNAROUND);
            state_reg <= TURN;
          end else if (do_grant) begin
            out_req   <= req_data[sel];
            out_type  <= req_type[sel];
            out_bank  <= sel;
            ptr_reg   <= sel;
            out_valid <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (batch_reg != CW'(WR_BATCH)) begin
              batch_reg <= batch_reg + 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        TURN: begin
          turn_reg <= turn_reg - 1'b1;
          if (turn_reg == TW'(1)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bank_scheduler.sv
// Directed bench for bank_scheduler: hand-computed scenario checks plus a
// free-running cycle model compared against the DUT every cycle.
module tb_bank_scheduler;
  localparam int BANKS        = 16;
  localparam int REQ_SIZE     = 50;
  localparam int T_BANK_BUSY  = 8;
  localparam int T_TURNAROUND = 4;
  localparam int WR_BATCH     = 8;
  localparam int IW           = 4;

  logic                           clk;
  logic                           rst_n;
  logic [BANKS-1:0]               req_valid;
  logic [BANKS-1:0]               req_type;
  logic [BANKS-1:0][REQ_SIZE-1:0] req_data;
  logic [BANKS-1:0]               grant_o;
  logic                           out_valid;
  logic                           out_ready;
  logic [REQ_SIZE-1:0]            out_req;
  logic                           out_type;
  logic [IW-1:0]                  out_bank;

  int errors;
  int checks;

  bank_scheduler #(
    .BANKS(BANKS), .REQ_SIZE(REQ_SIZE), .T_BANK_BUSY(T_BANK_BUSY),
    .T_TURNAROUND(T_TURNAROUND), .WR_BATCH(WR_BATCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
    .req_data(req_data), .grant_o(grant_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_req(out_req), .out_type(out_type), .out_bank(out_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference model: bank free times as absolute cycle numbers, remaining turnaround cycles.
  int                  cyc;
  logic                m_mode;
  int                  m_ptr;
  int                  m_batch;
  int                  m_turn;
  logic                m_hold;
  logic [REQ_SIZE-1:0] m_req;
  logic                m_type;
  int                  m_bank;
  int                  free_at [BANKS];

  initial cyc = 0;

  always @(negedge clk) begin
    logic [BANKS-1:0] want_grant;
    bit any_o;
    int pick;
    int b;
    want_grant = '0;
    if (!rst_n) begin
      m_mode = 1'b0; m_ptr = BANKS - 1; m_batch = 0; m_turn = 0; m_hold = 1'b0;
      m_req = '0; m_type = 1'b0; m_bank = 0;
      foreach (free_at[k]) free_at[k] = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_grant", grant_o, 0);
      check("rst_out_req", out_req, 0);
      check("rst_out_type", out_type, 0);
      check("rst_out_bank", out_bank, 0);
    end else begin
      check("model_out_valid", out_valid, m_hold);
      if (m_hold) begin
        check("model_out_req", out_req, m_req);
        check("model_out_type", out_type, m_type);
        check("model_out_bank", out_bank, m_bank);
        if (out_ready) begin
          $display("txn cycle=%0d bank=%0d type=%0d req=%h", cyc, m_bank, m_type, m_req);
          free_at[m_bank] = cyc + 1 + T_BANK_BUSY;
          if (m_batch < WR_BATCH) m_batch++;
          m_hold = 1'b0;
        end
      end else if (m_turn > 0) begin
        m_turn--;
      end else begin
        any_o = 0;
        pick  = -1;
        for (int k = 1; k <= BANKS; k++) begin
          b = (m_ptr + k) % BANKS;
          if (req_valid[b] && req_type[b] != m_mode) any_o = 1;
          if (req_valid[b] && req_type[b] == m_mode && cyc >= free_at[b] && pick < 0) pick = b;
        end
        if (any_o && (pick < 0 || m_batch == WR_BATCH)) begin
          m_mode  = ~m_mode;
          m_batch = 0;
          m_turn  = T_TURNAROUND;
        end else if (pick >= 0) begin
          want_grant[pick] = 1'b1;
          m_req  = req_data[pick];
          m_type = req_type[pick];
          m_bank = pick;
          m_ptr  = pick;
          m_hold = 1'b1;
        end
      end
      check("model_grant", grant_o, want_grant);
    end
    cyc++;
  end

  // Front-end queue depths; a grant pops one entry at the end of its cycle.
  int               q [BANKS];
  logic [BANKS-1:0] s_grant;
  logic             s_valid;
  logic             s_type;
  logic [IW-1:0]    s_bank;
  logic [15:0]      t2_want [13];
  logic [15:0]      t6_want [15];

  task automatic apply_q();
    for (int b = 0; b < BANKS; b++) req_valid[b] = (q[b] > 0);
  endtask

  task automatic clear_q();
    for (int b = 0; b < BANKS; b++) q[b] = 0;
    apply_q();
  endtask

  task automatic step();
    @(negedge clk);
    s_grant = grant_o; s_valid = out_valid; s_type = out_type; s_bank = out_bank;
    @(posedge clk);
    #1;
    for (int b = 0; b < BANKS; b++) if (s_grant[b] && q[b] > 0) q[b]--;
    apply_q();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int nwr;
    int w;
    errors = 0; checks = 0;
    rst_n = 1'b0; out_ready = 1'b0; req_type = '0; req_valid = '0;
    for (int b = 0; b < BANKS; b++) req_data[b] = {8'(8'hA0 + b), 42'(64'h0123_4567 * (b + 1))};
    t2_want = '{16'h0001, 0, 16'h0002, 0, 16'h0004, 0, 0, 0, 0, 0, 16'h0001, 0, 16'h0002};
    t6_want = '{16'h0020, 0, 16'h0100, 0, 16'h1000, 0, 0, 0, 0, 0, 16'h0020, 0, 16'h0100, 0, 16'h1000};
    clear_q();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_grant", grant_o, 0);
    check("reset_out_bank", out_bank, 0);
    rst_n = 1'b1;

    // Single read on bank 3 with five cycles of backpressure.
    q[3] = 1; apply_q();
    step(); check("t1_grant", s_grant, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_hold_valid", s_valid, 1);
      check("t1_hold_bank", s_bank, 3);
      check("t1_no_grant", s_grant, 0);
    end
    out_ready = 1'b1;
    step(); check("t1_hs_valid", s_valid, 1); check("t1_hs_bank", s_bank, 3);
    step(); check("t1_drop", s_valid, 0);

    // Round robin over banks 0..2 and the busy window on bank 0.
    q[0] = 100; q[1] = 100; q[2] = 100; apply_q();
    for (int i = 0; i < 13; i++) begin
      step(); check("t2_grant", s_grant, t2_want[i]);
    end
    clear_q(); repeat (3) step();

    // Write alone in read mode: switch, four TURN cycles, then grant.
    do_reset();
    req_type = 16'h0004; q[2] = 1; apply_q();
    for (int i = 0; i < 7; i++) begin
      step(); check("t3_grant", s_grant, (i == 5) ? 16'h0004 : 16'h0000);
    end
    check("t3_valid", s_valid, 1); check("t3_type", s_type, 1); check("t3_bank", s_bank, 2);
    clear_q(); repeat (3) step();

    // Write batch limit with a read waiting on bank 0.
    do_reset();
    req_type = 16'hFFF0;
    for (int b = 4; b < BANKS; b++) q[b] = 100;
    apply_q();
    nwr = 0;
    for (int i = 0; i < 28; i++) begin
      step();
      if (i == 1) begin q[0] = 1; apply_q(); end
      w = 0;
      if (i >= 5 && i <= 19 && ((i - 5) % 2 == 0)) w = 1 << (4 + (i - 5) / 2);
      if (i == 26) w = 1;
      check("t4_grant", s_grant, 64'(w));
      if (s_grant != 0 && i < 26) nwr++;
    end
    check("t4_write_issues", nwr, 8);
    check("t4_read_valid", s_valid, 1); check("t4_read_type", s_type, 0); check("t4_read_bank", s_bank, 0);
    clear_q(); repeat (6) step();

    // Asynchronous reset while a request is waiting in the output register.
    out_ready = 1'b0;
    do_reset();
    req_type = 16'h0002; q[1] = 5; q[6] = 5; q[9] = 5; apply_q();
    step(); check("t5_grant", s_grant, 16'h0040);
    step(); check("t5_issue_valid", s_valid, 1);
    #2; rst_n = 1'b0; #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_req", out_req, 0);
    check("t5_async_type", out_type, 0);
    check("t5_async_bank", out_bank, 0);
    check("t5_async_grant", grant_o, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(); check("t5_first_grant", s_grant, 16'h0040);
    out_ready = 1'b1;
    step(); check("t5_issue_bank", s_bank, 6);
    clear_q(); repeat (3) step();

    // Bank 5 stays requested across its own handshake; others fill the gap.
    do_reset();
    req_type = '0; q[5] = 100; q[8] = 100; q[12] = 100; apply_q();
    for (int i = 0; i < 15; i++) begin
      step(); check("t6_grant", s_grant, t6_want[i]);
    end
    clear_q(); repeat (3) step();

    // Mixed traffic with patterned backpressure, checked by the model alone.
    req_type = 16'hA5C3;
    for (int b = 0; b < BANKS; b++) q[b] = (b % 3) + 1;
    apply_q();
    for (int i = 0; i < 160; i++) begin
      out_ready = ((i % 5) != 3);
      step();
    end
    out_ready = 1'b1;
    clear_q(); repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
